// File: rtl/xorshift_pkg.sv
// Shared constants for the xorshift stream generator: seed-spreading constant,
// FSM state encoding and per-width shift triplet lookup.
package xorshift_pkg;

   localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_WARM = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   typedef struct packed {
      int a;
      int b;
      int c;
   } triplet_t;

   // Full-period shift triplets; anything other than 16/64 falls back to 32.
   function automatic triplet_t triplet(input int width);
      triplet_t t;
      case (width)
         16:      t = '{a: 7,  b: 9,  c: 8};
         64:      t = '{a: 13, b: 7,  c: 17};
         default: t = '{a: 13, b: 17, c: 5};
      endcase
      return t;
   endfunction

endpackage

// File: rtl/xorshift_step.sv
// One xorshift iteration, purely combinational: x ^= x<<a; x ^= x>>b; x ^= x<<c.
module xorshift_step
   import xorshift_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y
);

   localparam triplet_t T = triplet(WIDTH);

   logic [WIDTH-1:0] t1;
   logic [WIDTH-1:0] t2;

   always_comb begin
      t1 = x  ^ (x  << T.a);
      t2 = t1 ^ (t1 >> T.b);
      y  = t2 ^ (t2 << T.c);
   end

endmodule

// File: rtl/xorshift_stream.sv
// Multi-channel xorshift word-set source with seeding, warm-up discard and a
// valid/ready output stage that holds its word set while stalled.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_LOAD | channel registers take their seeds, warm-up timer takes WARMUP
// ST_WARM | all channels step each cycle, timer counts down, output invalid
// ST_RUN  | word set valid; channels step only on a handshake
module xorshift_stream
   import xorshift_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter int               CHANNELS = 1,
   parameter int               WARMUP   = 4,
   parameter logic [WIDTH-1:0] SEED     = WIDTH'(1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      seed_load,
   input  logic [WIDTH-1:0]          seed,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic                      busy
);

   state_t                    state_q;
   state_t                    state_d;
   logic [WIDTH-1:0]          base_q;
   logic [7:0]                cnt_q;
   logic                      cnt_tc;
   logic                      load_x;
   logic                      step_x;
   logic [CHANNELS*WIDTH-1:0] x_flat;

   assign cnt_tc = (cnt_q <= 8'd1);
   assign load_x = (state_q == ST_LOAD);
   assign step_x = !seed_load &&
                   ((state_q == ST_WARM) || ((state_q == ST_RUN) && out_ready));

   always_ff @(posedge clk) begin
      if (reset) begin
         base_q <= SEED;
      end else if (seed_load) begin
         base_q <= seed;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 8'd0;
      end else if (state_q == ST_LOAD) begin
         cnt_q <= 8'(WARMUP);
      end else if ((state_q == ST_WARM) && (cnt_q != 8'd0)) begin
         cnt_q <= cnt_q - 8'd1;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      localparam logic [63:0]      OFS     = GOLDEN * 64'(k);
      localparam logic [WIDTH-1:0] RST_MIX = SEED ^ OFS[WIDTH-1:0];
      localparam logic [WIDTH-1:0] RST_X   = (RST_MIX == '0) ? WIDTH'(1) : RST_MIX;

      logic [WIDTH-1:0] mixed;
      logic [WIDTH-1:0] ch_seed;
      logic [WIDTH-1:0] x_r;
      logic [WIDTH-1:0] x_nxt;

      // Zero is the one fixed point of xorshift, so it is never allowed in.
      assign mixed   = base_q ^ OFS[WIDTH-1:0];
      assign ch_seed = (mixed == '0) ? WIDTH'(1) : mixed;

      xorshift_step #(.WIDTH(WIDTH)) u_step (
         .x (x_r),
         .y (x_nxt)
      );

      always_ff @(posedge clk) begin
         if (reset) begin
            x_r <= RST_X;
         end else if (load_x) begin
            x_r <= ch_seed;
         end else if (step_x) begin
            x_r <= x_nxt;
         end
      end

      assign x_flat[k*WIDTH +: WIDTH] = x_r;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (seed_load) begin
         state_d = ST_LOAD;
      end else begin
         case (state_q)
            ST_LOAD: state_d = (WARMUP > 0) ? ST_WARM : ST_RUN;
            ST_WARM: if (cnt_tc) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_LOAD;
         endcase
      end
   end

   // Outputs decode registered state only, so out_ready never reaches them.
   always_comb begin
      out_valid = 1'b0;
      busy      = 1'b0;
      out_data  = '0;
      case (state_q)
         ST_LOAD, ST_WARM: busy = 1'b1;
         ST_RUN: begin
            out_valid = 1'b1;
            out_data  = x_flat;
         end
         default: busy = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_xorshift_stream.sv
// Directed bench for xorshift_stream: several configurations side by side,
// checked against hand values and a small reference xorshift model.
module tb_xorshift_stream;

   logic clk = 1'b0;
   logic reset;

   logic        seed_load_a, ready_a, valid_a, busy_a;
   logic [31:0] seed_a, data_a;
   logic        seed_load_b, ready_b, valid_b, busy_b;
   logic [31:0] seed_b;
   logic [127:0] data_b;
   logic        seed_load_c, ready_c, valid_c, busy_c;
   logic [31:0] seed_c, data_c;
   logic        seed_load_d, ready_d, valid_d, busy_d;
   logic [15:0] seed_d, data_d;

   int tests = 0;
   int fails = 0;

   logic [31:0] mb [4];
   bit          seen [0:65535];

   always #5 clk = ~clk;

   xorshift_stream #(.WIDTH(32), .CHANNELS(1), .WARMUP(0), .SEED(32'h1)) dut_a (
      .clk(clk), .reset(reset), .seed_load(seed_load_a), .seed(seed_a),
      .out_ready(ready_a), .out_valid(valid_a), .out_data(data_a), .busy(busy_a));

   xorshift_stream #(.WIDTH(32), .CHANNELS(4), .WARMUP(3), .SEED(32'h1)) dut_b (
      .clk(clk), .reset(reset), .seed_load(seed_load_b), .seed(seed_b),
      .out_ready(ready_b), .out_valid(valid_b), .out_data(data_b), .busy(busy_b));

   xorshift_stream #(.WIDTH(32), .CHANNELS(1), .WARMUP(1), .SEED(32'h1)) dut_c (
      .clk(clk), .reset(reset), .seed_load(seed_load_c), .seed(seed_c),
      .out_ready(ready_c), .out_valid(valid_c), .out_data(data_c), .busy(busy_c));

   xorshift_stream #(.WIDTH(16), .CHANNELS(1), .WARMUP(4), .SEED(16'h1)) dut_d (
      .clk(clk), .reset(reset), .seed_load(seed_load_d), .seed(seed_d),
      .out_ready(ready_d), .out_valid(valid_d), .out_data(data_d), .busy(busy_d));

   function automatic logic [31:0] st32(input logic [31:0] x);
      logic [31:0] v;
      v = x;
      v = v ^ (v << 13);
      v = v ^ (v >> 17);
      v = v ^ (v << 5);
      return v;
   endfunction

   function automatic logic [31:0] st32n(input logic [31:0] x, input int n);
      logic [31:0] v;
      v = x;
      for (int i = 0; i < n; i++) v = st32(v);
      return v;
   endfunction

   function automatic logic [15:0] st16(input logic [15:0] x);
      logic [15:0] v;
      v = x;
      v = v ^ (v << 7);
      v = v ^ (v >> 9);
      v = v ^ (v << 8);
      return v;
   endfunction

   function automatic logic [31:0] cs32(input logic [31:0] base, input int k);
      logic [63:0] g;
      logic [31:0] s;
      g = 64'h9E3779B97F4A7C15 * 64'(k);
      s = base ^ g[31:0];
      return (s == 32'h0) ? 32'h1 : s;
   endfunction

   function automatic logic [127:0] packb();
      return {mb[3], mb[2], mb[1], mb[0]};
   endfunction

   task automatic seed_model_b(input logic [31:0] base, input int warm);
      for (int k = 0; k < 4; k++) mb[k] = st32n(cs32(base, k), warm);
   endtask

   task automatic step_model_b();
      for (int k = 0; k < 4; k++) mb[k] = st32(mb[k]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [15:0] w, w1, w_last, d_first;
      int          rep, dup, zeros, inval;
      bit          r;

      reset = 1'b1;
      seed_load_a = 1'b0; seed_a = '0; ready_a = 1'b0;
      seed_load_b = 1'b0; seed_b = '0; ready_b = 1'b0;
      seed_load_c = 1'b0; seed_c = '0; ready_c = 1'b0;
      seed_load_d = 1'b0; seed_d = '0; ready_d = 1'b0;
      repeat (3) tick();

      chk("rst_valid_a", 128'(valid_a), 128'(1'b0));
      chk("rst_busy_a",  128'(busy_a),  128'(1'b1));
      chk("rst_data_a",  128'(data_a),  128'(32'h0));
      chk("rst_data_b",  data_b,        128'(0));
      chk("rst_busy_b",  128'(busy_b),  128'(1'b1));

      // Release with the consumer ready: warmup 0 and warmup 1 latencies.
      ready_a = 1'b1;
      ready_c = 1'b1;
      reset   = 1'b0;
      tick();
      chk("a_valid_first", 128'(valid_a), 128'(1'b1));
      chk("a_word1",       128'(data_a),  128'(32'h1));
      chk("c_warm_valid",  128'(valid_c), 128'(1'b0));
      chk("c_warm_busy",   128'(busy_c),  128'(1'b1));
      tick();
      chk("a_word2",       128'(data_a),  128'(32'h42021));
      chk("c_valid_rise",  128'(valid_c), 128'(1'b1));
      chk("c_word1",       128'(data_c),  128'(32'h42021));
      chk("c_busy_low",    128'(busy_c),  128'(1'b0));
      tick();
      chk("a_word3",       128'(data_a),  128'(st32(32'h42021)));
      ready_a = 1'b0;
      ready_c = 1'b0;
      tick();
      tick();
      chk("a_stall",       128'(data_a),  128'(st32(32'h42021)));

      // Four channels, random stalls against the model.
      seed_model_b(32'h1, 3);
      chk("b_valid_run", 128'(valid_b), 128'(1'b1));
      for (int i = 0; i < 200; i++) begin
         chk("b_rand", data_b, packb());
         r = 1'($urandom_range(0, 1));
         ready_b = r;
         tick();
         if (r) step_model_b();
      end

      // Zero seed in RUN with a concurrent (discarded) handshake.
      seed_b = 32'h0;
      seed_load_b = 1'b1;
      ready_b = 1'b1;
      tick();
      seed_load_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("b_reload_invalid", 128'(valid_b), 128'(1'b0));
         tick();
      end
      chk("b_reload_valid", 128'(valid_b), 128'(1'b1));
      mb[0] = st32n(32'h1, 3);
      mb[1] = st32n(32'h7F4A7C15, 3);
      mb[2] = st32n(cs32(32'h0, 2), 3);
      mb[3] = st32n(cs32(32'h0, 3), 3);
      for (int i = 0; i < 5; i++) begin
         chk("b_zero_seed_stream", data_b, packb());
         tick();
         step_model_b();
      end
      ready_b = 1'b0;

      // Zero and arbitrary seeds on the warmup-free instance.
      seed_a = 32'h0;
      seed_load_a = 1'b1;
      ready_a = 1'b1;
      tick();
      seed_load_a = 1'b0;
      ready_a = 1'b0;
      chk("a_load_invalid", 128'(valid_a), 128'(1'b0));
      tick();
      chk("a_zero_seed", 128'(data_a), 128'(32'h1));
      seed_a = 32'hDEADBEEF;
      seed_load_a = 1'b1;
      tick();
      seed_load_a = 1'b0;
      tick();
      chk("a_seed_word", 128'(data_a), 128'(32'hDEADBEEF));
      ready_a = 1'b1;
      tick();
      chk("a_seed_step", 128'(data_a), 128'(st32(32'hDEADBEEF)));
      ready_a = 1'b0;

      // Reseed in the middle of warm-up restarts the full count.
      seed_b = 32'h1234;
      seed_load_b = 1'b1;
      tick();
      seed_load_b = 1'b0;
      tick();
      tick();
      seed_b = 32'hABCD;
      seed_load_b = 1'b1;
      tick();
      seed_load_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("b_rewarm_invalid", 128'(valid_b), 128'(1'b0));
         tick();
      end
      seed_model_b(32'hABCD, 3);
      chk("b_rewarm_valid", 128'(valid_b), 128'(1'b1));
      chk("b_rewarm_data",  data_b,        packb());

      // Reset mid-warm with seed_load asserted: reset wins, SEED reused.
      seed_b = 32'h5555;
      seed_load_b = 1'b1;
      tick();
      seed_load_b = 1'b0;
      tick();
      reset = 1'b1;
      seed_b = 32'h7777;
      seed_load_b = 1'b1;
      tick();
      chk("b_rst_data",  data_b,        128'(0));
      chk("b_rst_busy",  128'(busy_b),  128'(1'b1));
      chk("b_rst_valid", 128'(valid_b), 128'(1'b0));
      reset = 1'b0;
      seed_load_b = 1'b0;
      tick();
      chk("a_after_rst", 128'(data_a), 128'(32'h1));
      for (int i = 0; i < 3; i++) begin
         chk("b_post_rst_invalid", 128'(valid_b), 128'(1'b0));
         tick();
      end
      seed_model_b(32'h1, 3);
      chk("b_post_rst_valid", 128'(valid_b), 128'(1'b1));
      chk("b_post_rst_data",  data_b,        packb());

      // 16-bit full-period check.
      tick();
      d_first = st16(st16(st16(st16(16'h1))));
      chk("d_valid", 128'(valid_d), 128'(1'b1));
      chk("d_word1", 128'(data_d),  128'(d_first));
      rep = 0; dup = 0; zeros = 0; inval = 0;
      w1 = '0; w_last = '0;
      ready_d = 1'b1;
      for (int i = 1; i <= 65536; i++) begin
         w = data_d;
         if (!valid_d) inval++;
         if (w == 16'h0) zeros++;
         if (i == 1) begin
            w1 = w;
            seen[w] = 1'b1;
         end else if (i <= 65535) begin
            if (w == w1) rep++;
            if (seen[w]) dup++;
            seen[w] = 1'b1;
         end else begin
            w_last = w;
         end
         tick();
      end
      ready_d = 1'b0;
      chk("d_no_early_repeat", 128'(rep),    128'(0));
      chk("d_no_duplicate",    128'(dup),    128'(0));
      chk("d_no_zero",         128'(zeros),  128'(0));
      chk("d_always_valid",    128'(inval),  128'(0));
      chk("d_period_wrap",     128'(w_last), 128'(d_first));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
